// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame-format defaults,
// kept in one place so the transmitter and receiver agree.
package uart_pkg;

  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_OS_RATE   = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input bit.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // NOTE: both stages reset to the line's idle level so a reset release
  // never looks like a falling edge on the serial line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversamples the synchronized line with an external tick,
// samples each bit at its centre and reports good bytes or framing errors.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int OS_RATE   = DEF_OS_RATE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clk_rx,
  input  logic                 i_rxd,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int CW = $clog2(OS_RATE);
  localparam int BW = $clog2(DATA_BITS) + 1;

  localparam logic [CW-1:0] CNT_HALF = CW'(OS_RATE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OS_RATE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic rxd_s;

  rx_state_e            state_q,     state_d;
  logic [CW-1:0]        cnt_q,       cnt_d;
  logic [BW-1:0]        bit_idx_q,   bit_idx_d;
  logic [DATA_BITS-1:0] shift_q,     shift_d;
  logic [DATA_BITS-1:0] rx_data_q,   rx_data_d;
  logic                 rx_valid_q,  rx_valid_d;
  logic                 frame_err_q, frame_err_d;

  uart_sync #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (i_rxd),
    .q     (rxd_s)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rxd_s) state_d = ST_START;
      end

      ST_START: begin
        if (i_clk_rx) begin
          if (cnt_q == CNT_HALF) begin
            cnt_d = '0;
            if (!rxd_s) begin
              bit_idx_d = '0;
              state_d   = ST_DATA;
            end else begin
              state_d   = ST_IDLE;  // glitch shorter than half a bit
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      ST_DATA: begin
        if (i_clk_rx) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            shift_d   = {rxd_s, shift_q[DATA_BITS-1:1]};
            bit_idx_d = bit_idx_q + BW'(1);
            if (bit_idx_q == BIT_LAST) state_d = ST_STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      ST_STOP: begin
        if (i_clk_rx) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (rxd_s) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = ST_BREAK;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      // Held-low line after a bad stop bit must not start a new frame.
      ST_BREAK: begin
        if (rxd_s) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign o_rx_data   = rx_data_q;
  assign o_rx_valid  = rx_valid_q;
  assign o_frame_err = frame_err_q;
  assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames,
// scored against a queue of expected strobes built from the frames sent.
module tb_uart_rx;

  localparam int DATA_BITS = 8;
  localparam int OS_RATE   = 16;
  localparam int TICK_DIV  = 16;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } exp_evt_t;

  logic       clk;
  logic       reset;
  logic       i_clk_rx;
  logic       i_rxd;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       o_frame_err;
  logic       o_busy;

  int         n_checks = 0;
  int         n_fail   = 0;
  exp_evt_t   exp_q[$];
  logic [7:0] exp_last;
  logic       tick_en;
  int         tdiv;

  uart_rx #(
    .DATA_BITS (DATA_BITS),
    .OS_RATE   (OS_RATE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_clk_rx    (i_clk_rx),
    .i_rxd       (i_rxd),
    .o_rx_data   (o_rx_data),
    .o_rx_valid  (o_rx_valid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running tick, one clk wide every TICK_DIV clocks; pausable.
  initial begin
    i_clk_rx = 1'b0;
    tdiv     = 0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_en && tdiv == TICK_DIV - 1) begin
        i_clk_rx = 1'b1;
        tdiv     = 0;
      end else begin
        i_clk_rx = 1'b0;
        if (tick_en) tdiv++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Strobe monitor: each valid/error pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (reset && (o_rx_valid || o_frame_err)) begin
      check("strobe_exclusive", 32'(o_rx_valid & o_frame_err), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        exp_evt_t e;
        e = exp_q.pop_front();
        check("strobe_kind_err", 32'(o_frame_err), 32'(e.is_err));
        if (!e.is_err) check("strobe_data", 32'(o_rx_data), 32'(e.data));
      end
    end
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int guard;
      guard = 0;
      do begin
        @(posedge clk);
        guard++;
      end while (!i_clk_rx && guard < 4 * TICK_DIV);
      if (!i_clk_rx) begin
        $display("FAIL tick_timeout: got no tick expected tick within %0d clk", 4 * TICK_DIV);
        $fatal(1);
      end
    end
  endtask

  task automatic drive(input logic v);
    #2 i_rxd = v;
  endtask

  task automatic stall_ticks(input int cycles);
    tick_en = 1'b0;
    repeat (cycles) @(posedge clk);
    check("stall_busy", 32'(o_busy), 32'd1);
    tick_en = 1'b1;
  endtask

  // Sends one frame; the line is left at the stop level on return.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int stall_bit);
    exp_evt_t e;
    e.is_err = !stop_bit;
    e.data   = data;
    exp_q.push_back(e);
    drive(1'b0);
    wait_ticks(OS_RATE);
    for (int i = 0; i < DATA_BITS; i++) begin
      drive(data[i]);
      if (i == stall_bit) begin
        wait_ticks(OS_RATE / 2);
        stall_ticks(1000);
        wait_ticks(OS_RATE / 2);
      end else begin
        wait_ticks(OS_RATE);
      end
    end
    drive(stop_bit);
    wait_ticks(OS_RATE);
    if (stop_bit) exp_last = data;
    check("missing_strobe", 32'(exp_q.size()), 32'd0);
    check("rx_data_hold", 32'(o_rx_data), 32'(exp_last));
  endtask

  initial begin
    logic [7:0] abort_byte;
    reset    = 1'b0;
    i_rxd    = 1'b1;
    tick_en  = 1'b1;
    exp_last = 8'h00;

    repeat (5) @(posedge clk);
    #1;
    check("rst_rx_data", 32'(o_rx_data), 32'd0);
    check("rst_rx_valid", 32'(o_rx_valid), 32'd0);
    check("rst_frame_err", 32'(o_frame_err), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    reset = 1'b1;
    wait_ticks(20);

    // Basic good frame.
    send_frame(8'hA5, 1'b1, -1);
    drive(1'b1);
    wait_ticks(OS_RATE);
    check("idle_after_a5", 32'(o_busy), 32'd0);

    // Start glitch shorter than half a bit.
    drive(1'b0);
    wait_ticks(4);
    drive(1'b1);
    wait_ticks(OS_RATE);
    check("glitch_busy", 32'(o_busy), 32'd0);
    check("glitch_no_strobe", 32'(exp_q.size()), 32'd0);

    // Framing error followed by a held-low line.
    send_frame(8'h3C, 1'b0, -1);
    wait_ticks(40);
    check("break_busy", 32'(o_busy), 32'd1);
    check("break_data_kept", 32'(o_rx_data), 32'h A5);
    drive(1'b1);
    wait_ticks(8);
    check("break_release_busy", 32'(o_busy), 32'd0);

    // Back-to-back frames with a single stop bit.
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    drive(1'b1);
    wait_ticks(OS_RATE);

    // Reset in the middle of data bit 4 of 0x81.
    abort_byte = 8'h81;
    drive(1'b0);
    wait_ticks(OS_RATE);
    for (int i = 0; i < 4; i++) begin
      drive(abort_byte[i]);
      wait_ticks(OS_RATE);
    end
    drive(abort_byte[4]);
    wait_ticks(OS_RATE / 2);
    #1 reset = 1'b0;
    #1;
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_rx_data", 32'(o_rx_data), 32'd0);
    check("midrst_rx_valid", 32'(o_rx_valid), 32'd0);
    check("midrst_frame_err", 32'(o_frame_err), 32'd0);
    i_rxd = 1'b1;
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    exp_last = 8'h00;
    wait_ticks(OS_RATE * 12);
    check("midrst_no_strobe", 32'(exp_q.size()), 32'd0);
    check("midrst_idle", 32'(o_busy), 32'd0);
    send_frame(8'h42, 1'b1, -1);
    drive(1'b1);
    wait_ticks(OS_RATE);

    // Ticks paused mid-frame.
    send_frame(8'h6B, 1'b1, 3);
    drive(1'b1);
    wait_ticks(OS_RATE);

    // Random frames, roughly a quarter with a bad stop bit.
    for (int n = 0; n < 8; n++) begin
      logic [7:0] d;
      logic       sb;
      d  = 8'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      send_frame(d, sb, -1);
      drive(1'b1);
      wait_ticks($urandom_range(2, 20));
    end
    wait_ticks(OS_RATE);
    check("final_idle", 32'(o_busy), 32'd0);
    check("final_no_pending", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
